// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the four-requester single-port RAM arbiter:
// requester indices, in-flight read tags and access-size encodings.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ = 4;

  // Array order is also priority order: lowest index wins.
  localparam int REQ_LD = 0;
  localparam int REQ_DW = 1;
  localparam int REQ_DR = 2;
  localparam int REQ_IR = 3;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

  localparam logic [1:0] BMUL_BYTE = 2'b00;
  localparam logic [1:0] BMUL_HALF = 2'b01;
  localparam logic [1:0] BMUL_WORD = 2'b10;

  function automatic logic req_is_write(input int idx);
    return (idx == REQ_LD) || (idx == REQ_DW);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_req_slot.sv
// One-deep pending slot for a pulsed request; a pulse bypasses straight to the arbiter when granted.
// Zero latency when uncontended; a pulse that hits an occupied, ungranted slot overwrites it and flags overrun.
module arb_req_slot #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pulse,
  input  logic [W-1:0] pulse_dat,
  input  logic         grant,
  output logic         cand_vld,
  output logic [W-1:0] cand_dat,
  output logic         pend_vld,
  output logic         overrun
);

  logic         pend;
  logic [W-1:0] held;

  // The stored entry always outranks a same-cycle pulse, so requests stay in order.
  assign cand_vld = pend | pulse;
  assign cand_dat = pend ? held : pulse_dat;
  assign pend_vld = pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      held    <= '0;
      overrun <= 1'b0;
    end else begin
      if (pulse) begin
        // Only a bypassed pulse (empty slot, granted now) leaves nothing behind.
        if (pend || !grant) begin
          held <= pulse_dat;
          pend <= 1'b1;
        end
        if (pend && !grant) begin
          overrun <= 1'b1;
        end
      end else if (grant) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fixed-priority sharing of one single-port RAM (ld_w > d_w > d_r > i_r), routing read data back by tag.
// Reads return the cycle after issue; losers wait in their slot, one access issued per cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_w_en,
  input  logic [ADDR_W-1:0] ld_w_addr,
  input  logic [DATA_W-1:0] ld_w_data,
  input  logic              i_r_en,
  input  logic [ADDR_W-1:0] i_r_addr,
  output logic [DATA_W-1:0] i_r_data,
  input  logic              d_r_en,
  input  logic [ADDR_W-1:0] d_r_addr,
  input  logic [1:0]        d_r_bmul,
  output logic [DATA_W-1:0] d_r_data,
  input  logic              d_w_en,
  input  logic [ADDR_W-1:0] d_w_addr,
  input  logic [DATA_W-1:0] d_w_data,
  input  logic [1:0]        d_w_bmul,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_bmul,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              overrun
);

  localparam int PW = ADDR_W + DATA_W + 2;

  logic [NUM_REQ-1:0] pulse;
  logic [NUM_REQ-1:0] cand_vld;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] slot_ovr;
  logic [PW-1:0]      pulse_dat [NUM_REQ];
  logic [PW-1:0]      cand_dat  [NUM_REQ];
  logic [PW-1:0]      win_dat;

  tag_e              tag_q;
  tag_e              tag_d;
  logic [DATA_W-1:0] i_hold;
  logic [DATA_W-1:0] d_hold;

  assign pulse[REQ_LD] = ld_w_en;
  assign pulse[REQ_DW] = d_w_en;
  assign pulse[REQ_DR] = d_r_en;
  assign pulse[REQ_IR] = i_r_en;

  // Payload is {addr, wdata, bmul}; loader and fetch are always full-word.
  assign pulse_dat[REQ_LD] = {ld_w_addr, ld_w_data, BMUL_WORD};
  assign pulse_dat[REQ_DW] = {d_w_addr, d_w_data, d_w_bmul};
  assign pulse_dat[REQ_DR] = {d_r_addr, {DATA_W{1'b0}}, d_r_bmul};
  assign pulse_dat[REQ_IR] = {i_r_addr, {DATA_W{1'b0}}, BMUL_WORD};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    arb_req_slot #(
      .W (PW)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .pulse     (pulse[g]),
      .pulse_dat (pulse_dat[g]),
      .grant     (grant[g]),
      .cand_vld  (cand_vld[g]),
      .cand_dat  (cand_dat[g]),
      .pend_vld  (pend[g]),
      .overrun   (slot_ovr[g])
    );
  end

  always_comb begin
    logic found;
    grant   = '0;
    win_dat = '0;
    ram_we  = 1'b0;
    found   = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (cand_vld[r] && !found) begin
        grant[r] = 1'b1;
        win_dat  = cand_dat[r];
        ram_we   = req_is_write(r);
        found    = 1'b1;
      end
    end
  end

  assign ram_en = |cand_vld;
  assign {ram_addr, ram_wdata, ram_bmul} = win_dat;

  always_comb begin
    tag_d = TAG_NONE;
    if (grant[REQ_DR]) begin
      tag_d = TAG_D;
    end else if (grant[REQ_IR]) begin
      tag_d = TAG_I;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q  <= TAG_NONE;
      i_hold <= '0;
      d_hold <= '0;
    end else begin
      tag_q <= tag_d;
      if (tag_q == TAG_I) begin
        i_hold <= ram_rdata;
      end
      if (tag_q == TAG_D) begin
        d_hold <= ram_rdata;
      end
    end
  end

  // Returning data is passed through in its arrival cycle, then held.
  assign i_r_data = (tag_q == TAG_I) ? ram_rdata : i_hold;
  assign d_r_data = (tag_q == TAG_D) ? ram_rdata : d_hold;

  assign busy    = (|pend) || (tag_q != TAG_NONE);
  assign overrun = |slot_ovr;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural request/queue model plus RAM model, directed then random traffic.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_w_en, i_r_en, d_r_en, d_w_en;
  logic [31:0] ld_w_addr, ld_w_data, i_r_addr, d_r_addr, d_w_addr, d_w_data;
  logic [1:0]  d_r_bmul, d_w_bmul;
  logic [31:0] i_r_data, d_r_data;
  logic        ram_en, ram_we, busy, overrun;
  logic [31:0] ram_addr, ram_wdata;
  logic [1:0]  ram_bmul;
  logic [31:0] ram_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_w_en(ld_w_en), .ld_w_addr(ld_w_addr), .ld_w_data(ld_w_data),
    .i_r_en(i_r_en), .i_r_addr(i_r_addr), .i_r_data(i_r_data),
    .d_r_en(d_r_en), .d_r_addr(d_r_addr), .d_r_bmul(d_r_bmul), .d_r_data(d_r_data),
    .d_w_en(d_w_en), .d_w_addr(d_w_addr), .d_w_data(d_w_data), .d_w_bmul(d_w_bmul),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_bmul(ram_bmul), .ram_rdata(ram_rdata), .busy(busy), .overrun(overrun)
  );

  function automatic logic [31:0] init_word(input logic [7:0] idx);
    case (idx)
      8'h04:   return 32'h0050_0093;
      8'h10:   return 32'h1111_1111;
      8'h02:   return 32'h2222_2222;
      8'h0C:   return 32'h3333_3333;
      8'h09:   return 32'h9999_9999;
      default: return {idx, idx, idx, idx} ^ 32'h5A00_0000;
    endcase
  endfunction

  // RAM macro model: word-indexed, registered read.
  bit [31:0]  ram_mem [256];
  bit [255:0] ram_wr;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr[9:2]] <= ram_wdata;
        ram_wr[ram_addr[9:2]]  <= 1'b1;
      end else begin
        ram_rdata <= ram_wr[ram_addr[9:2]] ? ram_mem[ram_addr[9:2]] : init_word(ram_addr[9:2]);
      end
    end
  end

  // Reference model. Requester k: 0 loader write, 1 data write, 2 data read, 3 fetch.
  bit          m_pend [4];
  logic [31:0] m_addr [4];
  logic [31:0] m_data [4];
  logic [1:0]  m_bmul [4];
  int          m_tag;            // 0 idle, 1 fetch, 2 data read
  logic [31:0] m_exp_rd, m_ih, m_dh;
  bit          m_ovr;
  bit [31:0]   exp_mem [256];
  bit          exp_wr [256];

  bit          cp [4];
  logic [31:0] cia [4], cid [4];
  logic [1:0]  cib [4];
  int          cw;
  logic [31:0] ca, cd;
  logic [1:0]  cb;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_pend[k] = 1'b0;
    m_tag = 0; m_exp_rd = '0; m_ih = '0; m_dh = '0; m_ovr = 1'b0;
  endtask

  task automatic check_cycle();
    @(negedge clk);
    cp[0] = ld_w_en; cia[0] = ld_w_addr; cid[0] = ld_w_data; cib[0] = 2'b10;
    cp[1] = d_w_en;  cia[1] = d_w_addr;  cid[1] = d_w_data;  cib[1] = d_w_bmul;
    cp[2] = d_r_en;  cia[2] = d_r_addr;  cid[2] = '0;        cib[2] = d_r_bmul;
    cp[3] = i_r_en;  cia[3] = i_r_addr;  cid[3] = '0;        cib[3] = 2'b10;
    cw = -1;
    for (int k = 0; k < 4; k++) begin
      if (cw < 0 && (m_pend[k] || cp[k])) cw = k;
    end
    if (cw >= 0) begin
      ca = m_pend[cw] ? m_addr[cw] : cia[cw];
      cd = m_pend[cw] ? m_data[cw] : cid[cw];
      cb = (cw == 0 || cw == 3) ? 2'b10 : (m_pend[cw] ? m_bmul[cw] : cib[cw]);
    end
    chk("ram_en", ram_en, cw >= 0);
    chk("ram_we", ram_we, cw == 0 || cw == 1);
    if (cw >= 0) begin
      chk("ram_addr", ram_addr, ca);
      chk("ram_bmul", ram_bmul, cb);
      if (cw <= 1) chk("ram_wdata", ram_wdata, cd);
    end
    chk("i_r_data", i_r_data, (m_tag == 1) ? m_exp_rd : m_ih);
    chk("d_r_data", d_r_data, (m_tag == 2) ? m_exp_rd : m_dh);
    chk("busy", busy, m_pend[0] || m_pend[1] || m_pend[2] || m_pend[3] || m_tag != 0);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic advance();
    @(posedge clk);
    // The RAM sees the access even in a reset cycle, so memory contents follow it.
    if (cw == 0 || cw == 1) begin
      exp_mem[ca[9:2]] = cd;
      exp_wr[ca[9:2]]  = 1'b1;
    end
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_tag == 1) m_ih = m_exp_rd;
      if (m_tag == 2) m_dh = m_exp_rd;
      m_tag = (cw == 2) ? 2 : (cw == 3) ? 1 : 0;
      if (cw >= 2) m_exp_rd = exp_wr[ca[9:2]] ? exp_mem[ca[9:2]] : init_word(ca[9:2]);
      for (int k = 0; k < 4; k++) begin
        bit issued_old, issued_new;
        issued_old = m_pend[k] && cw == k;
        issued_new = !m_pend[k] && cw == k;
        if (issued_old) m_pend[k] = 1'b0;
        if (cp[k] && !issued_new) begin
          if (m_pend[k]) m_ovr = 1'b1;
          m_addr[k] = cia[k]; m_data[k] = cid[k]; m_bmul[k] = cib[k];
          m_pend[k] = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic cycle();
    check_cycle();
    advance();
  endtask

  task automatic idle_inputs();
    ld_w_en = 0; i_r_en = 0; d_r_en = 0; d_w_en = 0;
  endtask

  initial begin
    idle_inputs();
    ld_w_addr = '0; ld_w_data = '0; i_r_addr = '0; d_r_addr = '0;
    d_w_addr = '0; d_w_data = '0; d_r_bmul = 2'b10; d_w_bmul = 2'b10;
    rst_n = 1'b0;
    model_reset();
    cw = -1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check_cycle();
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_i", i_r_data, 0);
    chk("rst_d", d_r_data, 0);
    chk("rst_ram_en", ram_en, 0);
    advance();

    // Uncontended fetch
    i_r_en = 1; i_r_addr = 32'h10;
    check_cycle();
    chk("t1_ram_en", ram_en, 1);
    chk("t1_addr", ram_addr, 32'h10);
    advance();
    idle_inputs();
    check_cycle();
    chk("t1_i_data", i_r_data, 32'h0050_0093);
    advance();
    check_cycle();
    chk("t1_busy", busy, 0);
    advance();

    // Data read and fetch collide
    d_r_en = 1; d_r_addr = 32'h40; d_r_bmul = 2'b10; i_r_en = 1; i_r_addr = 32'h08;
    check_cycle();
    chk("t2_addr_d", ram_addr, 32'h40);
    advance();
    idle_inputs();
    check_cycle();
    chk("t2_d_data", d_r_data, 32'h1111_1111);
    chk("t2_addr_i", ram_addr, 32'h08);
    advance();
    check_cycle();
    chk("t2_i_data", i_r_data, 32'h2222_2222);
    advance();
    check_cycle();
    chk("t2_d_hold", d_r_data, 32'h1111_1111);
    chk("t2_i_hold", i_r_data, 32'h2222_2222);
    advance();

    // Write then read-back
    d_w_en = 1; d_w_addr = 32'h40; d_w_data = 32'hDEAD_BEEF; d_w_bmul = 2'b10;
    cycle();
    idle_inputs();
    d_r_en = 1; d_r_addr = 32'h40;
    cycle();
    idle_inputs();
    check_cycle();
    chk("t3_d_data", d_r_data, 32'hDEAD_BEEF);
    chk("t3_i_keep", i_r_data, 32'h2222_2222);
    advance();

    // Loader burst starves a fetch
    for (int c = 0; c < 4; c++) begin
      ld_w_en = 1; ld_w_addr = 32'(c * 4); ld_w_data = 32'hC0DE_0000 + 32'(c);
      i_r_en = (c == 1); i_r_addr = 32'h30;
      check_cycle();
      chk("t4_ld_we", ram_we, 1);
      chk("t4_ld_addr", ram_addr, 32'(c * 4));
      advance();
    end
    idle_inputs();
    check_cycle();
    chk("t4_i_addr", ram_addr, 32'h30);
    chk("t4_i_we", ram_we, 0);
    advance();
    check_cycle();
    chk("t4_i_data", i_r_data, 32'h3333_3333);
    chk("t4_ovr", overrun, 0);
    advance();

    // Overrun: second fetch pulse overwrites the first
    for (int c = 0; c < 4; c++) begin
      ld_w_en = 1; ld_w_addr = 32'h100 + 32'(c * 4); ld_w_data = 32'hAB00_0000 + 32'(c);
      i_r_en = (c < 2); i_r_addr = (c == 0) ? 32'h20 : 32'h24;
      cycle();
    end
    idle_inputs();
    check_cycle();
    chk("t5_ovr", overrun, 1);
    chk("t5_addr", ram_addr, 32'h24);
    advance();
    check_cycle();
    chk("t5_i_data", i_r_data, 32'h9999_9999);
    advance();

    // Reset with a data read in flight
    d_r_en = 1; d_r_addr = 32'h40;
    cycle();
    idle_inputs();
    rst_n = 0;
    cycle();
    rst_n = 1;
    check_cycle();
    chk("t6_d_data", d_r_data, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ovr", overrun, 0);
    advance();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if (rst_n) begin
        ld_w_en = ($urandom_range(0, 99) < 15);
        d_w_en  = ($urandom_range(0, 99) < 25);
        d_r_en  = ($urandom_range(0, 99) < 30);
        i_r_en  = ($urandom_range(0, 99) < 35);
      end else begin
        idle_inputs();
      end
      ld_w_addr = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      d_w_addr  = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      d_r_addr  = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      i_r_addr  = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      ld_w_data = $urandom;
      d_w_data  = $urandom;
      d_r_bmul  = 2'($urandom_range(0, 2));
      d_w_bmul  = 2'($urandom_range(0, 2));
      cycle();
    end
    idle_inputs();
    rst_n = 1;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM (1-cycle read latency) between four requesters: program loader write, core data write, core data read, core instruction read.
- Sits between the core's split instruction/data memory interfaces and the unified RAM macro.
- Latches one-cycle request pulses, grants one access per cycle by fixed priority, and returns read data to the owning requester.
- Holds returned read data stable until that requester's next read completes.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active low
- ld_w_en  in  1  loader write pulse
- ld_w_addr  in  ADDR_W  loader write address
- ld_w_data  in  DATA_W  loader write data
- i_r_en  in  1  instruction read pulse
- i_r_addr  in  ADDR_W  instruction read address
- i_r_data  out  DATA_W  instruction read data
- d_r_en  in  1  data read pulse
- d_r_addr  in  ADDR_W  data read address
- d_r_bmul  in  2  data read size (00 byte, 01 half, 10 word)
- d_r_data  out  DATA_W  data read data
- d_w_en  in  1  data write pulse
- d_w_addr  in  ADDR_W  data write address
- d_w_data  in  DATA_W  data write data
- d_w_bmul  in  2  data write size
- ram_en  out  1  RAM access this cycle
- ram_we  out  1  1 = write
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_bmul  out  2  access size (word 10 for loader and instruction reads)
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read is issued
- busy  out  1  any request pending or read in flight
- overrun  out  1  sticky: a new pulse arrived while the same requester was still pending

Behaviour:
- One clock; reset is synchronous and active-low: clk, rst_n.
- Reset values: all pending flags 0, in-flight tag idle, i_r_data and d_r_data holds 0, overrun 0.
- Reset mid-operation drops any pending or in-flight access. A response that arrives afterwards is discarded.
- Request capture:
  - Each requester has one pending slot holding its address, data and bmul.
  - A pulse sampled high either is issued in the same cycle (combinational bypass into the arbiter) or is stored as pending.
- Arbitration: fixed priority ld_w > d_w > d_r > i_r.
  - Candidates are pending slots plus same-cycle pulses.
  - Exactly one access is issued per cycle. Losers stay pending.
- RAM outputs are combinational from the winning candidate. ram_en = 0 and ram_we = 0 when no candidate exists.
- Uncontended latency:
  - A read pulse in cycle N drives the RAM in cycle N; data is available on the requester's output in cycle N+1, identical to a bare RAM.
  - Each lost grant adds 1 cycle.
- Read return:
  - The in-flight tag (none/I/D), registered at issue, routes ram_rdata in the next cycle.
  - x_r_data = ram_rdata when the tag matches this cycle; otherwise the held value.
  - The hold register loads on that same edge.
- Writes produce no response. A write followed by a read of the same address one cycle later returns the new data (RAM write-first behaviour is not assumed; order is guaranteed by the issue sequence).
- Overrun:
  - A pulse for a requester whose slot is pending and not granted this cycle overwrites the slot with the new address/data and sets overrun.
  - overrun clears only on reset.
- Simultaneous events:
  - A pulse and a grant of the same slot in one cycle means the old entry is issued and the new one stored; this is not an overrun.
  - I-read and D-read in the same cycle: D issues, I is delayed 1 cycle.
- busy = any pending OR tag not idle. It is combinational only over registered state.

Decomposition:
- Shared package: requester index constants (REQ_LD, REQ_DW, REQ_DR, REQ_IR), tag encodings (TAG_NONE, TAG_I, TAG_D), bmul encodings (BMUL_BYTE, BMUL_HALF, BMUL_WORD).
- One natural sub-module, arb_req_slot: pending flag plus address/data/bmul latch with overrun detect. Instantiate it four times; the top holds the priority mux and return routing.

Test Plan:
1. Reset, then an i_r_en pulse with i_r_addr = 0x10 and RAM[0x10] = 0x00500093 -> ram_en = 1, ram_addr = 0x10 in the same cycle; i_r_data = 0x00500093 next cycle; busy low afterwards.
2. d_r_en at 0x40 and i_r_en at 0x08 in the same cycle -> D issued in cycle N, I in N+1. d_r_data is valid at N+1, i_r_data at N+2, each holding its value thereafter.
3. d_w_en 0x40 <= 0xDEADBEEF with bmul 10, then d_r_en 0x40 next cycle -> d_r_data = 0xDEADBEEF; i_r_data unchanged.
4. ld_w_en held on 4 consecutive cycles (addr 0..12) while i_r_en pulses in cycle 1 -> loader writes issue back-to-back; the I read issues in cycle 4 and returns in cycle 5; overrun stays 0.
5. Two i_r_en pulses (0x20 then 0x24) while blocked by continuous loader writes -> overrun = 1; the eventual read uses 0x24.
6. rst_n low for 1 cycle while a D read is in flight -> d_r_data = 0 and busy = 0 after reset; the late ram_rdata is ignored.
